// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// trap_ctrl : trap/MRET sequencer that owns the CSR write port during traps
// Rev 1.0
// ============================================================================
module trap_ctrl #(
  parameter int XLEN         = 64,
  parameter bit MTVEC_VEC_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exc_valid,
  input  logic            exc_interrupt,
  input  logic [4:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_valid,
  output logic            req_ready,
  input  logic            w_csr_valid,
  input  logic [11:0]     w_csr_wa,
  input  logic [XLEN-1:0] w_csr_wd,
  input  logic [XLEN-1:0] mtvec_rd,
  input  logic [XLEN-1:0] mepc_rd,
  input  logic [XLEN-1:0] mstatus_rd,
  output logic            csr_valid,
  output logic [11:0]     csr_wa,
  output logic [XLEN-1:0] csr_wd,
  output logic            stall,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [2:0] c_idle     = 3'd0;
  localparam logic [2:0] c_w_mepc   = 3'd1;
  localparam logic [2:0] c_w_mcause = 3'd2;
  localparam logic [2:0] c_w_mtval  = 3'd3;
  localparam logic [2:0] c_w_mstat  = 3'd4;
  localparam logic [2:0] c_redir    = 3'd5;

  localparam logic [11:0] c_addr_mstatus = 12'h300;
  localparam logic [11:0] c_addr_mepc    = 12'h341;
  localparam logic [11:0] c_addr_mcause  = 12'h342;
  localparam logic [11:0] c_addr_mtval   = 12'h343;

  logic [2:0]      r_state;
  logic [2:0]      w_next_state;
  logic            r_mret;
  logic            r_intr;
  logic [4:0]      r_code;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tval;

  logic            w_idle;
  logic            w_vec_mode;
  logic [XLEN-1:0] w_trap_base;
  logic [XLEN-1:0] w_vec_off;
  logic [XLEN-1:0] w_trap_pc;
  logic [XLEN-1:0] w_mcause;
  logic [XLEN-1:0] w_mstat_new;

  assign w_idle = (r_state == c_idle);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: begin
        if (exc_valid)       w_next_state = c_w_mepc;
        else if (mret_valid) w_next_state = c_w_mstat;
      end
      c_w_mepc:   w_next_state = c_w_mcause;
      // Interrupts carry no trap value, so mtval is left untouched.
      c_w_mcause: w_next_state = r_intr ? c_w_mstat : c_w_mtval;
      c_w_mtval:  w_next_state = c_w_mstat;
      c_w_mstat:  w_next_state = c_redir;
      c_redir:    w_next_state = c_idle;
      default:    w_next_state = c_idle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_idle;
      r_mret  <= 1'b0;
      r_intr  <= 1'b0;
      r_code  <= 5'd0;
      r_pc    <= '0;
      r_tval  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_idle) begin
        if (exc_valid) begin
          r_mret <= 1'b0;
          r_intr <= exc_interrupt;
          r_code <= exc_code;
          r_pc   <= exc_pc;
          r_tval <= exc_tval;
        end else if (mret_valid) begin
          r_mret <= 1'b1;
          r_intr <= 1'b0;
        end
      end
    end
  end

  generate
    if (MTVEC_VEC_EN) begin : g_vec
      assign w_vec_mode = (mtvec_rd[1:0] == 2'b01) & r_intr;
    end else begin : g_direct
      assign w_vec_mode = 1'b0;
    end
  endgenerate

  assign w_trap_base = {mtvec_rd[XLEN-1:2], 2'b00};
  assign w_vec_off   = {{(XLEN-7){1'b0}}, r_code, 2'b00};
  assign w_trap_pc   = w_trap_base + (w_vec_mode ? w_vec_off : '0);
  assign w_mcause    = {r_intr, {(XLEN-6){1'b0}}, r_code};

  // Trap stacks MIE into MPIE; MRET restores it and re-arms MPIE.
  always_comb begin
    w_mstat_new        = mstatus_rd;
    w_mstat_new[12:11] = 2'b11;
    if (r_mret) begin
      w_mstat_new[3] = mstatus_rd[7];
      w_mstat_new[7] = 1'b1;
    end else begin
      w_mstat_new[7] = mstatus_rd[3];
      w_mstat_new[3] = 1'b0;
    end
  end

  always_comb begin
    req_ready      = w_idle;
    stall          = ~w_idle;
    flush          = ~w_idle;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    csr_valid      = 1'b1;
    csr_wa         = 12'h000;
    csr_wd         = '0;
    case (r_state)
      c_idle: begin
        // Reset masks the pass-through so the CSR file sees no write.
        csr_valid = reset & w_csr_valid;
        csr_wa    = reset ? w_csr_wa : 12'h000;
        csr_wd    = reset ? w_csr_wd : '0;
      end
      c_w_mepc: begin
        csr_wa = c_addr_mepc;
        csr_wd = r_pc;
      end
      c_w_mcause: begin
        csr_wa = c_addr_mcause;
        csr_wd = w_mcause;
      end
      c_w_mtval: begin
        csr_wa = c_addr_mtval;
        csr_wd = r_tval;
      end
      c_w_mstat: begin
        csr_wa = c_addr_mstatus;
        csr_wd = w_mstat_new;
      end
      c_redir: begin
        csr_valid      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = r_mret ? mepc_rd : w_trap_pc;
      end
      default: begin
        csr_valid = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// tb_trap_ctrl : directed + randomized checks of trap_ctrl against a model
// Rev 1.0
// ============================================================================
module tb_trap_ctrl;

  localparam int XLEN = 64;
  localparam bit VEC  = 1'b1;

  logic            clk;
  logic            reset;
  logic            exc_valid;
  logic            exc_interrupt;
  logic [4:0]      exc_code;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic            mret_valid;
  logic            req_ready;
  logic            w_csr_valid;
  logic [11:0]     w_csr_wa;
  logic [XLEN-1:0] w_csr_wd;
  logic [XLEN-1:0] mtvec_rd;
  logic [XLEN-1:0] mepc_rd;
  logic [XLEN-1:0] mstatus_rd;
  logic            csr_valid;
  logic [11:0]     csr_wa;
  logic [XLEN-1:0] csr_wd;
  logic            stall;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [11:0]     wa;
    logic [XLEN-1:0] wd;
  } wr_t;

  trap_ctrl #(.XLEN(XLEN), .MTVEC_VEC_EN(VEC)) dut (
    .clk(clk), .reset(reset),
    .exc_valid(exc_valid), .exc_interrupt(exc_interrupt), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .mret_valid(mret_valid),
    .req_ready(req_ready),
    .w_csr_valid(w_csr_valid), .w_csr_wa(w_csr_wa), .w_csr_wd(w_csr_wd),
    .mtvec_rd(mtvec_rd), .mepc_rd(mepc_rd), .mstatus_rd(mstatus_rd),
    .csr_valid(csr_valid), .csr_wa(csr_wa), .csr_wd(csr_wd),
    .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] mstat_model(input bit is_mret, input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] keep;
    keep = ms & ~64'h1888;
    if (is_mret) return keep | 64'h1880 | (64'(ms[7]) << 3);
    return keep | 64'h1800 | (64'(ms[3]) << 7);
  endfunction

  task automatic idle_inputs();
    exc_valid   = 1'b0;
    mret_valid  = 1'b0;
    w_csr_valid = 1'b0;
    w_csr_wa    = 12'h0;
    w_csr_wd    = '0;
  endtask

  // One request from acceptance through the first idle cycle after redirect.
  task automatic run_req(input bit is_mret, input bit also_mret, input bit intr,
                         input logic [4:0] code, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] tval, input logic [XLEN-1:0] mtvec,
                         input logic [XLEN-1:0] mstat, input logic [XLEN-1:0] mepc,
                         input bit fwd, input logic [11:0] fwa,
                         input logic [XLEN-1:0] fwdd, input bit noisy);
    wr_t             q[$];
    logic [XLEN-1:0] target;
    int              lat;
    q = {};
    if (!is_mret) begin
      q.push_back('{wa: 12'h341, wd: pc});
      q.push_back('{wa: 12'h342, wd: (64'(intr) << 63) | 64'(code)});
      if (!intr) q.push_back('{wa: 12'h343, wd: tval});
    end
    q.push_back('{wa: 12'h300, wd: mstat_model(is_mret, mstat)});
    lat = q.size() + 1;
    if (is_mret) target = mepc;
    else begin
      target = mtvec & ~64'h3;
      if (VEC && (mtvec % 4 == 1) && intr) target = target + 64'(code) * 4;
    end

    @(posedge clk); #1;
    mtvec_rd      = mtvec;
    mstatus_rd    = mstat;
    mepc_rd       = mepc;
    exc_valid     = !is_mret;
    mret_valid    = is_mret || also_mret;
    exc_interrupt = intr;
    exc_code      = code;
    exc_pc        = pc;
    exc_tval      = tval;
    w_csr_valid   = fwd;
    w_csr_wa      = fwa;
    w_csr_wd      = fwdd;
    @(negedge clk);
    chk("accept_ready", req_ready, 1);
    chk("accept_stall", stall, 0);
    chk("fwd_valid", csr_valid, fwd);
    if (fwd) begin
      chk("fwd_wa", csr_wa, fwa);
      chk("fwd_wd", csr_wd, fwdd);
    end

    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(posedge clk); #1;
      if (noisy && cyc < lat) begin
        exc_valid     = 1'b1;
        mret_valid    = 1'($urandom);
        exc_interrupt = 1'($urandom);
        exc_code      = 5'($urandom);
        exc_pc        = {$urandom, $urandom};
        w_csr_valid   = 1'b1;
        w_csr_wa      = 12'($urandom);
        w_csr_wd      = {$urandom, $urandom};
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      chk("busy_ready", req_ready, 0);
      chk("busy_stall", stall, 1);
      chk("busy_flush", flush, 1);
      if (cyc < lat) begin
        chk("seq_valid", csr_valid, 1);
        chk("seq_wa", csr_wa, q[cyc-1].wa);
        chk("seq_wd", csr_wd, q[cyc-1].wd);
        chk("seq_redir", redirect_valid, 0);
      end else begin
        chk("redir_csr_valid", csr_valid, 0);
        chk("redir_valid", redirect_valid, 1);
        chk("redir_pc", redirect_pc, target);
      end
    end

    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("post_ready", req_ready, 1);
    chk("post_stall", stall, 0);
    chk("post_flush", flush, 0);
    chk("post_redir", redirect_valid, 0);
    chk("post_csr_valid", csr_valid, 0);
  endtask

  initial begin
    reset         = 1'b0;
    idle_inputs();
    exc_interrupt = 1'b0;
    exc_code      = 5'd0;
    exc_pc        = '0;
    exc_tval      = '0;
    mtvec_rd      = '0;
    mepc_rd       = '0;
    mstatus_rd    = '0;

    // Reset holds everything quiet even with a pending W-stage write.
    w_csr_valid = 1'b1;
    w_csr_wa    = 12'h340;
    w_csr_wd    = 64'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_csr_valid", csr_valid, 0);
    chk("rst_csr_wa", csr_wa, 0);
    chk("rst_csr_wd", csr_wd, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redir", redirect_valid, 0);
    chk("rst_redir_pc", redirect_pc, 0);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel_ready", req_ready, 1);

    // Synchronous exception, direct target.
    run_req(0, 0, 0, 5'd2, 64'h8000_0010, 64'hDEAD, 64'h8000_0101, 64'h8, 64'h0,
            0, 12'h0, 64'h0, 0);
    // Vectored interrupt.
    run_req(0, 0, 1, 5'd7, 64'h8000_0040, 64'h55, 64'h8000_0101, 64'h8, 64'h0,
            0, 12'h0, 64'h0, 0);
    // MRET.
    run_req(1, 0, 0, 5'd0, 64'h0, 64'h0, 64'h8000_0101, 64'h80, 64'h8000_0200,
            0, 12'h0, 64'h0, 0);
    // Exception and MRET together with an older W-stage write.
    run_req(0, 1, 0, 5'd4, 64'h8000_0080, 64'hBEEF, 64'h8000_0000, 64'h0, 64'h9000,
            1, 12'h340, 64'hCAFE_F00D, 0);
    // Requests and W-stage writes hammering a busy sequencer.
    run_req(0, 0, 0, 5'd11, 64'h8000_00C0, 64'h77, 64'h8000_0101, 64'h1888, 64'h0,
            0, 12'h0, 64'h0, 1);

    // Reset in the middle of W_MTVAL.
    @(posedge clk); #1;
    exc_valid     = 1'b1;
    exc_interrupt = 1'b0;
    exc_code      = 5'd3;
    exc_pc        = 64'h8000_0100;
    @(posedge clk); #1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_mtval_wa", csr_wa, 12'h343);
    reset = 1'b0;
    #1;
    chk("midrst_stall", stall, 0);
    chk("midrst_flush", flush, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_csr_valid", csr_valid, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int n = 0; n < 24; n++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      run_req(kind == 2, (kind != 2) && ($urandom_range(0, 3) == 0), kind == 1,
              5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom), 12'($urandom), {$urandom, $urandom}, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
